// File: rtl/sprite_blitter.sv
// sprite_blitter: CHIP-8/SCHIP XOR sprite blitter with pixel collision detect and screen clear.
// Latency: a draw of B bytes accepted in cycle 0 pulses done in cycle 9*B+2; a clear pulses done in cycle 2^VA+1.
// Backpressure: hold stalls FETCH/PIX one cycle per asserted cycle; clear ignores hold; start pulses outside IDLE are dropped.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   draw_en, cls_en          start pulses, sampled only in IDLE (draw_en has priority)
//   I, x0, y0, rows, wide    sprite base address, origin, row count (0 = 16), 16-px row select
//   mem_raddr / mem_d        program memory read port, 1-cycle latency
//   vram_raddr / vram_q      VRAM read port {y,x}, 1-cycle latency, shared with scan-out
//   vram_we/waddr/d          VRAM write port
//   hold                     scan-out owns the VRAM read port this cycle
//   busy, done, col          status: not idle, completion pulse, sticky collision flag
module sprite_blitter #(
  parameter int X_BITS     = 6,
  parameter int Y_BITS     = 5,
  parameter int ADDR_WIDTH = 12,
  parameter int WRAP       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     draw_en,
  input  logic                     cls_en,
  input  logic [ADDR_WIDTH-1:0]    I,
  input  logic [X_BITS-1:0]        x0,
  input  logic [Y_BITS-1:0]        y0,
  input  logic [3:0]               rows,
  input  logic                     wide,
  output logic [ADDR_WIDTH-1:0]    mem_raddr,
  input  logic [7:0]               mem_d,
  output logic [X_BITS+Y_BITS-1:0] vram_raddr,
  input  logic                     vram_q,
  output logic                     vram_we,
  output logic [X_BITS+Y_BITS-1:0] vram_waddr,
  output logic                     vram_d,
  input  logic                     hold,
  output logic                     busy,
  output logic                     done,
  output logic                     col
);

  localparam int VA = X_BITS + Y_BITS;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_PIX   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CLS   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Draw parameters captured at acceptance; last_n is the index of the final sprite byte.
  typedef struct packed {
    logic [X_BITS-1:0] x0;
    logic [Y_BITS-1:0] y0;
    logic [4:0]        last_n;
    logic              wide;
  } draw_t;

  // Screen address of pixel k of byte n, with a clip flag in the MSB.
  // Sums carry one extra bit so overflow past the screen edge is visible in clip mode.
  function automatic logic [VA:0] pix_addr(
    input logic [X_BITS-1:0] fx0,
    input logic [Y_BITS-1:0] fy0,
    input logic              fwide,
    input logic [4:0]        n,
    input logic [2:0]        k
  );
    logic [X_BITS:0] cx;
    logic [Y_BITS:0] cy;
    logic [3:0]      ro;
    logic            clip;
    ro   = fwide ? n[4:1] : n[3:0];
    cx   = {1'b0, fx0}
         + {{(X_BITS-3){1'b0}}, fwide & n[0], 3'b000}
         + {{(X_BITS-2){1'b0}}, k};
    cy   = {1'b0, fy0} + {{(Y_BITS-3){1'b0}}, ro};
    clip = (WRAP == 0) && (cx[X_BITS] || cy[Y_BITS]);
    return {clip, cy[Y_BITS-1:0], cx[X_BITS-1:0]};
  endfunction

  logic [2:0]            state_q, state_d;
  draw_t                 prm_q, prm_d;
  logic [4:0]            n_q, n_d;
  logic [2:0]            k_q, k_d;
  logic [7:0]            byte_q, byte_d;
  logic                  col_q, col_d;
  logic [ADDR_WIDTH-1:0] mem_raddr_q, mem_raddr_d;
  logic [VA-1:0]         vram_raddr_q, vram_raddr_d;
  logic                  clip_q, clip_d;
  // Read issued last cycle: its data is on vram_q now and its write-back happens now.
  logic                  rd_vld_q, rd_vld_d;
  logic                  rd_bit_q, rd_bit_d;
  logic [VA-1:0]         wr_addr_q, wr_addr_d;
  logic [VA-1:0]         cls_cnt_q, cls_cnt_d;

  logic [VA:0]           first_pix;
  logic [VA:0]           next_pix;
  logic                  pix_bit;
  logic [3:0]            rows_m1;

  always_comb begin
    state_d      = state_q;
    prm_d        = prm_q;
    n_d          = n_q;
    k_d          = k_q;
    byte_d       = byte_q;
    col_d        = col_q;
    mem_raddr_d  = mem_raddr_q;
    vram_raddr_d = vram_raddr_q;
    clip_d       = clip_q;
    rd_vld_d     = 1'b0;
    rd_bit_d     = rd_bit_q;
    wr_addr_d    = wr_addr_q;
    cls_cnt_d    = cls_cnt_q;

    // rows == 0 wraps to 15 here, i.e. 16 rows.
    rows_m1   = rows - 4'd1;
    first_pix = pix_addr(prm_q.x0, prm_q.y0, prm_q.wide, n_q, 3'd0);
    next_pix  = pix_addr(prm_q.x0, prm_q.y0, prm_q.wide, n_q, k_q + 3'd1);
    // mem_d is only valid from the first PIX cycle of a byte; later bits come from the latched copy.
    pix_bit   = (k_q == 3'd0) ? mem_d[7] : byte_q[3'd7 - k_q];

    if (rd_vld_q && vram_q && rd_bit_q) begin
      col_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (draw_en) begin
          prm_d.x0     = x0;
          prm_d.y0     = y0;
          prm_d.wide   = wide;
          prm_d.last_n = wide ? {rows_m1, 1'b1} : {1'b0, rows_m1};
          n_d          = 5'd0;
          k_d          = 3'd0;
          col_d        = 1'b0;
          mem_raddr_d  = I;
          state_d      = S_FETCH;
        end else if (cls_en) begin
          cls_cnt_d = '0;
          state_d   = S_CLS;
        end
      end

      S_FETCH: begin
        // Prime the read address for pixel 0 so it is presented in the first PIX cycle.
        if (!hold) begin
          {clip_d, vram_raddr_d} = first_pix;
          k_d                    = 3'd0;
          state_d                = S_PIX;
        end
      end

      S_PIX: begin
        if (k_q == 3'd0) begin
          byte_d = mem_d;
        end
        if (!hold) begin
          rd_vld_d  = !clip_q;
          rd_bit_d  = pix_bit;
          wr_addr_d = vram_raddr_q;
          k_d       = k_q + 3'd1;
          if (k_q != 3'd7) begin
            {clip_d, vram_raddr_d} = next_pix;
          end else if (n_q == prm_q.last_n) begin
            state_d = S_DRAIN;
          end else begin
            n_d         = n_q + 5'd1;
            mem_raddr_d = mem_raddr_q + 1'b1;
            state_d     = S_FETCH;
          end
        end
      end

      S_DRAIN: state_d = S_DONE;

      S_CLS: begin
        cls_cnt_d = cls_cnt_q + 1'b1;
        if (&cls_cnt_q) begin
          state_d = S_DONE;
        end
      end

      S_DONE:  state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      prm_q        <= '0;
      n_q          <= '0;
      k_q          <= '0;
      byte_q       <= '0;
      col_q        <= 1'b0;
      mem_raddr_q  <= '0;
      vram_raddr_q <= '0;
      clip_q       <= 1'b0;
      rd_vld_q     <= 1'b0;
      rd_bit_q     <= 1'b0;
      wr_addr_q    <= '0;
      cls_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      prm_q        <= prm_d;
      n_q          <= n_d;
      k_q          <= k_d;
      byte_q       <= byte_d;
      col_q        <= col_d;
      mem_raddr_q  <= mem_raddr_d;
      vram_raddr_q <= vram_raddr_d;
      clip_q       <= clip_d;
      rd_vld_q     <= rd_vld_d;
      rd_bit_q     <= rd_bit_d;
      wr_addr_q    <= wr_addr_d;
      cls_cnt_q    <= cls_cnt_d;
    end
  end

  // Draw write-backs and clear writes never overlap: rd_vld_q is only set from PIX.
  assign vram_we    = (state_q == S_CLS) | rd_vld_q;
  assign vram_waddr = (state_q == S_CLS) ? cls_cnt_q : wr_addr_q;
  assign vram_d     = (state_q == S_CLS) ? 1'b0 : (vram_q ^ rd_bit_q);
  assign mem_raddr  = mem_raddr_q;
  assign vram_raddr = vram_raddr_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign col        = col_q;

endmodule
